// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, FSM state type and lane helpers for the command master.
package ahb_pkg;

    localparam int unsigned DATA_WIDTH = 32;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Size/alignment combinations the bus cannot carry as a single transfer.
    function automatic logic cmd_illegal(input logic [2:0] size, input logic [1:0] lane);
        case (size)
            HSIZE_BYTE: cmd_illegal = 1'b0;
            HSIZE_HALF: cmd_illegal = lane[0];
            HSIZE_WORD: cmd_illegal = (lane != 2'b00);
            default:    cmd_illegal = 1'b1;
        endcase
    endfunction

    function automatic logic [DATA_WIDTH-1:0] size_mask(input logic [2:0] size);
        case (size)
            HSIZE_BYTE: size_mask = DATA_WIDTH'(32'h0000_00FF);
            HSIZE_HALF: size_mask = DATA_WIDTH'(32'h0000_FFFF);
            default:    size_mask = '1;
        endcase
    endfunction

    // Right-justified data moved onto the byte lanes selected by the address.
    function automatic logic [DATA_WIDTH-1:0] place_wdata(input logic [DATA_WIDTH-1:0] data,
                                                          input logic [2:0]            size,
                                                          input logic [1:0]            lane);
        place_wdata = (data & size_mask(size)) << {lane, 3'b000};
    endfunction

    // Lane-placed bus data brought back to right-justified, zero-extended form.
    function automatic logic [DATA_WIDTH-1:0] extract_rdata(input logic [DATA_WIDTH-1:0] data,
                                                            input logic [2:0]            size,
                                                            input logic [1:0]            lane);
        extract_rdata = (data >> {lane, 3'b000}) & size_mask(size);
    endfunction

endpackage

// File: rtl/ahb_cmd_fifo.sv
// Synchronous command FIFO; registered occupancy flags, wrap-bit pointers.
module ahb_cmd_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type payload_t = logic [31:0]
) (
    input  logic     hclk,
    input  logic     hresetn,
    input  logic     push,
    input  payload_t in_data,
    output logic     in_ready,
    input  logic     pop,
    output payload_t out_data,
    output logic     empty
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned PW = IW + 1;

    payload_t        mem [DEPTH];
    logic [PW-1:0]   wptr_q, rptr_q;
    logic [PW-1:0]   wptr_d, rptr_d;
    logic            push_c, pop_c;
    logic            full_d, empty_d;

    assign push_c = push & in_ready;
    assign pop_c  = pop & ~empty;

    // Next-pointer and flag computation; in_ready is the registered complement of full.
    always_comb begin
        wptr_d  = wptr_q + PW'(push_c);
        rptr_d  = rptr_q + PW'(pop_c);
        full_d  = (wptr_d[IW] != rptr_d[IW]) && (wptr_d[IW-1:0] == rptr_d[IW-1:0]);
        empty_d = (wptr_d == rptr_d);
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            empty    <= 1'b1;
            in_ready <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            empty    <= empty_d;
            in_ready <= ~full_d;
        end
    end

    always_ff @(posedge hclk) begin
        if (push_c) begin
            mem[wptr_q[IW-1:0]] <= in_data;
        end
    end

    assign out_data = mem[rptr_q[IW-1:0]];

endmodule

// File: rtl/ahb_cmd_master.sv
// Command-driven AHB-Lite master: one non-pipelined transfer per buffered command.
module ahb_cmd_master
    import ahb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned CMD_DEPTH  = 2
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [2:0]            cmd_size,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [31:0]           cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err,
    output logic                  hsel_o,
    output logic [1:0]            htrans_o,
    output logic [2:0]            hsize_o,
    output logic                  hwrite_o,
    output logic [ADDR_WIDTH-1:0] haddr_o,
    output logic [31:0]           hwdata_o,
    input  logic                  hready_i,
    input  logic [1:0]            hresp_i,
    input  logic [31:0]           hrdata_i
);

    typedef struct packed {
        logic                  write;
        logic [2:0]            size;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    cmd_t cmd_in_c, head_c;
    logic fifo_empty_c;
    logic pop_c;
    logic bus_err_c;

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    hsel_d, hwrite_d, rsp_valid_d, rsp_err_d;
    logic [1:0]              htrans_d;
    logic [2:0]              hsize_d;
    logic [ADDR_WIDTH-1:0]   haddr_d;
    logic [DATA_WIDTH-1:0]   hwdata_d, rsp_rdata_d;

    assign cmd_in_c = '{write: cmd_write, size: cmd_size, addr: cmd_addr, wdata: cmd_wdata};

    ahb_cmd_fifo #(
        .DEPTH     (CMD_DEPTH),
        .payload_t (cmd_t)
    ) u_fifo (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .push     (cmd_valid),
        .in_data  (cmd_in_c),
        .in_ready (cmd_ready),
        .pop      (pop_c),
        .out_data (head_c),
        .empty    (fifo_empty_c)
    );

    // Next state and next registered outputs; everything holds unless a transition moves it.
    always_comb begin
        state_d     = state_q;
        wdata_d     = wdata_q;
        hsel_d      = hsel_o;
        htrans_d    = htrans_o;
        hsize_d     = hsize_o;
        hwrite_d    = hwrite_o;
        haddr_d     = haddr_o;
        hwdata_d    = hwdata_o;
        rsp_valid_d = rsp_valid;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        pop_c       = 1'b0;
        bus_err_c   = (hresp_i & HRESP_ERROR) != HRESP_OKAY;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_c) begin
                    pop_c = 1'b1;
                    if (cmd_illegal(head_c.size, head_c.addr[1:0])) begin
                        // Rejected locally: no bus cycle is issued.
                        state_d     = ST_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end else begin
                        state_d  = ST_ADDR;
                        hsel_d   = 1'b1;
                        htrans_d = HTRANS_NONSEQ;
                        hsize_d  = head_c.size;
                        hwrite_d = head_c.write;
                        haddr_d  = head_c.addr;
                        wdata_d  = head_c.wdata;
                    end
                end
            end
            ST_ADDR: begin
                if (hready_i) begin
                    state_d  = ST_DATA;
                    hsel_d   = 1'b0;
                    htrans_d = HTRANS_IDLE;
                    hwdata_d = place_wdata(wdata_q, hsize_o, haddr_o[1:0]);
                end
            end
            ST_DATA: begin
                if (hready_i) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus_err_c;
                    rsp_rdata_d = (hwrite_o || bus_err_c) ? '0
                                : extract_rdata(hrdata_i, hsize_o, haddr_o[1:0]);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q   <= ST_IDLE;
            wdata_q   <= '0;
            hsel_o    <= 1'b0;
            htrans_o  <= HTRANS_IDLE;
            hsize_o   <= '0;
            hwrite_o  <= 1'b0;
            haddr_o   <= '0;
            hwdata_o  <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wdata_q   <= wdata_d;
            hsel_o    <= hsel_d;
            htrans_o  <= htrans_d;
            hsize_o   <= hsize_d;
            hwrite_o  <= hwrite_d;
            haddr_o   <= haddr_d;
            hwdata_o  <= hwdata_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

endmodule
